// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with load and prescaled auto-scan
// Ports: clk, reset (async, active-high); enable, load, address, scan, divisor in;
//        out (one-hot select), index, wrap (sweep-complete pulse), active out.
module scan_decoder #(
  parameter int ADDR_WIDTH = 2,
  parameter int DIV_WIDTH = 8,
  localparam int NOUT = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  scan,
  input  logic [DIV_WIDTH-1:0]  divisor,
  output logic [NOUT-1:0]       out,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  wrap,
  output logic                  active
);
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
  state_t state, state_n;
  logic [DIV_WIDTH-1:0] tick, tick_n;
  logic [ADDR_WIDTH-1:0] index_n;
  logic step;
  always_comb begin
    // tick above a freshly lowered divisor counts as a match
    step = state == SCAN && enable && scan && !load && tick >= divisor;
    state_n = load ? (scan ? SCAN : HOLD) : (!enable || state == IDLE) ? state : scan ? SCAN : HOLD;
    index_n = load ? address : step ? index + 1'b1 : index;
    tick_n = (load || step || (state == HOLD && enable && scan)) ? '0 :
             (state == SCAN && enable && scan) ? tick + 1'b1 : tick;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tick <= '0;
      index <= '0;
      out <= '0;
      wrap <= 1'b0;
      active <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      index <= index_n;
      out <= (enable && state_n != IDLE) ? NOUT'(1) << index_n : '0;
      wrap <= step && &index;
      active <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed bench with a behavioural model for 2-bit and 3-bit decoders
module tb_scan_decoder;
  logic clk = 0, reset = 1, enable = 0, load = 0, scan = 0;
  logic [2:0] addr = '0;
  logic [7:0] divisor = '0;
  logic [3:0] out2;
  logic [1:0] index2;
  logic wrap2, active2;
  logic [7:0] out3;
  logic [2:0] index3;
  logic wrap3, active3;
  int compared = 0, mismatched = 0;
  int m_mode[2], m_idx[2], m_tick[2], m_out[2], m_wrap[2];

  always #5 clk = ~clk;

  scan_decoder #(.ADDR_WIDTH(2), .DIV_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .address(addr[1:0]),
    .scan(scan), .divisor(divisor), .out(out2), .index(index2), .wrap(wrap2), .active(active2));
  scan_decoder #(.ADDR_WIDTH(3), .DIV_WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .address(addr),
    .scan(scan), .divisor(divisor), .out(out3), .index(index3), .wrap(wrap3), .active(active3));

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 idle, 1 hold, 2 scan; k=0 is the 4-output decoder, k=1 the 8-output one
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      n = k ? 8 : 4;
      if (reset) begin
        m_mode[k] = 0; m_idx[k] = 0; m_tick[k] = 0; m_out[k] = 0; m_wrap[k] = 0;
      end else begin
        m_wrap[k] = 0;
        if (load) begin
          m_idx[k] = int'(addr) % n;
          m_tick[k] = 0;
          m_mode[k] = scan ? 2 : 1;
        end else if (enable && m_mode[k] == 1) begin
          if (scan) begin m_mode[k] = 2; m_tick[k] = 0; end
        end else if (enable && m_mode[k] == 2) begin
          if (!scan) m_mode[k] = 1;
          else if (m_tick[k] >= int'(divisor)) begin
            m_wrap[k] = (m_idx[k] == n - 1) ? 1 : 0;
            m_idx[k] = (m_idx[k] + 1) % n;
            m_tick[k] = 0;
          end else m_tick[k]++;
        end
        m_out[k] = (enable && m_mode[k] != 0) ? (1 << m_idx[k]) : 0;
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    check("out2", int'(out2), m_out[0]);
    check("index2", int'(index2), m_idx[0]);
    check("wrap2", int'(wrap2), m_wrap[0]);
    check("active2", int'(active2), int'(m_mode[0] != 0));
    check("out3", int'(out3), m_out[1]);
    check("index3", int'(index3), m_idx[1]);
    check("wrap3", int'(wrap3), m_wrap[1]);
    check("active3", int'(active3), int'(m_mode[1] != 0));
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out", int'(out2), 0);
    check("rst_active", int'(active2), 0);
    reset = 0;
    enable = 1;
    scan = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_out", int'(out2), 0);
      check("idle_active", int'(active2), 0);
    end
    scan = 0;
    for (int a = 0; a < 4; a++) begin
      addr = 3'(a); load = 1;
      @(negedge clk);
      load = 0;
      check("load_out", int'(out2), 1 << a);
      check("load_wrap", int'(wrap2), 0);
      check("load_active", int'(active2), 1);
    end
    addr = 3'd2; load = 1;
    @(negedge clk);
    load = 0; enable = 0;
    @(negedge clk);
    check("dis_out", int'(out2), 0);
    check("dis_index", int'(index2), 2);
    enable = 1;
    @(negedge clk);
    check("en_out", int'(out2), 4'b0100);
    divisor = 8'd2; scan = 1; addr = 3'd0; load = 1;
    @(negedge clk);
    load = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      check("scan3_index", int'(index2), (c / 3) % 4);
      check("scan3_wrap", int'(wrap2), int'(c == 12));
    end
    divisor = 8'd0; addr = 3'd0; load = 1;
    @(negedge clk);
    load = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      check("sweep_out", int'(out3), 1 << (c % 8));
      check("sweep_wrap", int'(wrap3), int'(c == 8));
    end
    scan = 0;
    repeat (3) @(negedge clk);
    check("drop_index", int'(index3), 5);
    addr = 3'd3; scan = 1; load = 1;
    @(negedge clk);
    addr = 3'd1;
    @(negedge clk);
    load = 0;
    check("ovr_index", int'(index2), 1);
    check("ovr_wrap", int'(wrap2), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    check("arst_out", int'(out2), 0);
    check("arst_index", int'(index2), 0);
    check("arst_active", int'(active2), 0);
    check("arst_wrap", int'(wrap2), 0);
    #1 reset = 0;
    repeat (2) @(negedge clk);
    check("post_rst_out", int'(out2), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/scan_decoder.md
# scan_decoder

Registered, parametrised N-to-2^N one-hot decoder with an optional auto-scan mode. The select index is either loaded from an address input or stepped by an internal prescaled counter, and a wrap pulse marks each completed sweep. The block drives row/channel selects and LED or display multiplexing in the FPGA study designs. It is the clocked, width-generic successor of the 2-to-4 structural decoder.

## Interface
- ADDR_WIDTH, 2, index width; output count NOUT = 2^ADDR_WIDTH (ADDR_WIDTH ≥ 1)
- DIV_WIDTH, 8, width of the scan-rate divisor
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  1 = outputs active and scan advances; 0 = outputs zero, index and tick counter frozen
- load  input  1  single-cycle strobe: capture `address` into index
- address  input  ADDR_WIDTH  index loaded on `load`
- scan  input  1  1 = auto-step index, 0 = hold index
- divisor  input  DIV_WIDTH  step period in cycles minus 1 (0 = step every enabled cycle)
- out  output  NOUT  registered one-hot select, bit `index`
- index  output  ADDR_WIDTH  current select index (registered)
- wrap  output  1  one-cycle pulse when index steps NOUT-1 -> 0 in scan
- active  output  1  1 when state is HOLD or SCAN

## Operation
- States: IDLE (after reset, nothing selected), HOLD (static index), SCAN (stepping index).
- Reset values: state IDLE, index 0, tick 0, out all 0, wrap 0, active 0.
- load=1 at an edge, from any state: index <= address; tick <= 0; next state is SCAN if scan=1, else HOLD. Load applies regardless of `enable`.
- IDLE with load=0: stays IDLE; `scan` alone does not leave IDLE.
- HOLD with scan=1 (no load): moves to SCAN with tick <= 0. The index does not step on that edge.
- SCAN with scan=0 (no load): moves to HOLD and keeps the current index. It does not step on that edge.
- SCAN, enable=1: if tick == divisor, index <= index+1 (mod NOUT) and tick <= 0. Otherwise tick <= tick+1.
- wrap is 1 only for the cycle after an edge where index stepped from NOUT-1 to 0 by scanning. A load to 0 never raises wrap.
- enable=0: tick, index and state are frozen; load still works.
- divisor is sampled live every cycle. If tick > divisor after a change, the next enabled cycle treats it as a match: step, and clear tick.
- Output rule, registered on the same edge as index: out <= (enable && next state != IDLE) ? (1 << next index) : 0. out is either all-zero or exactly one-hot. It is never multi-hot.
- active = (state != IDLE).
- Width rules: tick is DIV_WIDTH bits. index increment wraps naturally in ADDR_WIDTH bits. Comparisons are unsigned.

## Timing
- All outputs are registered with no combinational input-to-output path.
- Latency from load, enable or scan change to out/index is 1 edge.
- Scan step period is divisor+1 enabled cycles. A full sweep is NOUT·(divisor+1) enabled cycles.
- Priority when events coincide: reset > load > scan/hold transition > tick step.
- Reset mid-scan: out, index and wrap go to 0 asynchronously, without waiting for clk. The first edge after reset deasserts behaves as IDLE.
- A load on the same edge as a scheduled step or wrap overrides it: no step and no wrap.

## Test plan
- Reset, then with enable=1: load address 0,1,2,3 in turn with scan=0 (ADDR_WIDTH=2). Each edge after a load gives out = 0001, 0010, 0100, 1000; wrap=0; active=1.
- enable=0 in HOLD at index 2 -> out=0000 and index stays 2. enable=1 -> out=0100 on the next edge.
- Load 0 with scan=1, divisor=2. Index steps every 3 cycles: 0,1,2,3,0. wrap is high for exactly 1 cycle as index becomes 0, 12 cycles after the load.
- With divisor=0, ADDR_WIDTH=3: a sweep of 8 cycles, with out rotating from 00000001 to 10000000 and back. Drop scan mid-sweep at index 5 -> index holds at 5.
- Load address=1 on the same edge index would wrap from 3 -> index=1, wrap=0. Assert reset between edges mid-scan -> out=0 and index=0 immediately, active=0.
- IDLE after reset with scan=1 and no load -> out stays 0000 for 10 cycles and active stays 0.
